conv_viterbi_decoder: RTL and testbench
=======================================

# conv_viterbi_decoder

Hard-decision Viterbi decoder for the team's rate-1/3, constraint-length-3 convolutional code. It sits directly downstream of the convolutional generator and the channel. Each cycle it accepts one received 3-bit codeword and emits one decoded data bit after a fixed survivor depth. It uses a 4-state add-compare-select (ACS) datapath with register-exchange survivor memory.

## Interface
Parameters:
- DEPTH, 16: survivor path length in symbols (decision delay); legal range 4..64.
- METRIC_W, 6: path-metric width in bits; minimum 4.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  received codeword present this cycle.
- i_sig0  input  1  received c0 (generator u^u[-1]^u[-2]).
- i_sig1  input  1  received c1 (generator u^u[-2]).
- i_sig2  input  1  received c2 (generator u^u[-1]).
- o_valid  output  1  o_data holds a decoded bit this cycle (one-cycle pulse per bit).
- o_data  output  1  decoded data bit.

## Operation
- Trellis state s={s1,s0}, with s0=u[n-1] and s1=u[n-2].
  - Expected codeword for input u from state s: c0=u^s0^s1, c1=u^s1, c2=u^s0.
  - Next state = {s0, u}.
- Branch metric: Hamming distance (0..3) between {i_sig0,i_sig1,i_sig2} and the expected codeword.
- ACS for each new state s'={a,u}:
  - Predecessors are {0,a} and {1,a}.
  - Candidate = old metric + branch metric, saturating at 2^METRIC_W-1.
  - Select the smaller candidate. On a tie, choose predecessor {0,a}.
- Normalization: after ACS, subtract the minimum of the four new metrics from all four, in the same cycle. The stored minimum is therefore always 0.
- Survivor (register exchange): path[s'] <= {path[pred][DEPTH-2:0], u}, where u = s'[0].
- Best state = the state with the minimum stored metric. On a tie, choose the lowest index.
- Decision bit = path[best][DEPTH-1], taken from the paths after the update for the current symbol.
- Symbol counter: saturating at DEPTH, incremented on each accepted symbol. A decision is emitted once the counter, including the current symbol, reaches DEPTH.
- i_valid=0: metrics, paths and counter hold; no output is produced.
- Reset values:
  - Metrics: state 0 = 0; states 1..3 = 2^METRIC_W-1 (encoder starts in state 00).
  - Paths: all 0. Counter: 0.
  - o_valid = 0, o_data = 0.

## Timing
- Accepted symbol n (i_valid=1 at edge k) updates metrics and paths at edge k.
- o_valid/o_data are registered:
  - Asserted for the cycle following edge k when the counter reaches or has reached DEPTH.
  - o_data = decoded u[n-DEPTH+1].
- Latency from input symbol n to its decoded bit: DEPTH-1 further accepted symbols, plus 1 clock.
- The first o_valid follows the DEPTH-th accepted symbol. After that, one output per accepted symbol, with no bubbles except those mirrored from i_valid gaps.
- Throughput: one symbol per clock. No backpressure; the decoder never stalls.
- rst asserted mid-stream: all state clears immediately. o_valid drops asynchronously. The counter restarts, so the first output after release again needs DEPTH symbols.
- Metric saturation: a candidate at the ceiling stays at 2^METRIC_W-1 and does not wrap. With normalization, live metrics never exceed 3*(constraint span); METRIC_W=4 is sufficient for correctness.

## Test plan
1. Reset, then 40 symbols of 000 with i_valid=1 -> first o_valid after the 16th symbol (DEPTH=16); 25 outputs total, all o_data=0.
2. Encode u=1,0,1,1,0,0 followed by 20 zeros from state 00. Codewords: 111, 101, 001, 010, 011, 110, then 000.
   - Required: decoded stream begins 1,0,1,1,0,0, then zeros.
3. As scenario 2 but with the 2nd codeword corrupted to 100 (one bit flipped) -> identical decoded output.
4. As scenario 2 with i_valid deasserted for 3 cycles between each symbol -> same bit sequence. Outputs appear only one clock after accepted symbols; no o_valid during gaps.
5. Assert rst for one cycle after 10 symbols of scenario 2, then replay the full scenario 2 -> no o_valid until 16 post-reset symbols; output matches scenario 2.
6. Random u (1000 bits), encoded, with isolated single-bit errors spaced at least 12 symbols apart -> decoded stream equals u delayed by DEPTH symbols, zero bit errors. With METRIC_W=4, no metric wrap occurs.

Source files
------------

// File: rtl/conv_viterbi_decoder.sv
// -----------------------------------------------------------------------------
// conv_viterbi_decoder
//
// Purpose:
//   Hard-decision Viterbi decoder for the rate-1/3, K=3 convolutional code
//   (c0 = u^u[-1]^u[-2], c1 = u^u[-2], c2 = u^u[-1]).
//   - The datapath is a 4-state add-compare-select (ACS) array.
//   - Path metrics are normalized every symbol.
//   - Survivors use register exchange.
//   - One decoded bit leaves per accepted symbol once DEPTH symbols have
//     been seen.
//
// Parameters:
//   DEPTH    survivor path length / decision delay in symbols (4..64)
//   METRIC_W path-metric width in bits (>= 4)
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   i_valid  received codeword present this cycle
//   i_sig0   received c0
//   i_sig1   received c1
//   i_sig2   received c2
//   o_valid  registered one-cycle pulse per decoded bit
//   o_data   decoded data bit (valid while o_valid is high)
// -----------------------------------------------------------------------------
module conv_viterbi_decoder #(
    parameter int DEPTH    = 16,
    parameter int METRIC_W = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    input  logic i_sig0,
    input  logic i_sig1,
    input  logic i_sig2,
    output logic o_valid,
    output logic o_data
);

    localparam logic [METRIC_W-1:0] M_MAX = '1;
    localparam int                  CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(DEPTH);

    // State index is {s1,s0}, with s0 = u[n-1] and s1 = u[n-2].
    logic [METRIC_W-1:0] metric_q [4];
    logic [METRIC_W-1:0] metric_d [4];
    logic [DEPTH-1:0]    path_q   [4];
    logic [DEPTH-1:0]    path_d   [4];
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                o_valid_q;
    logic                o_valid_d;
    logic                o_data_q;
    logic                o_data_d;

    // ACS intermediates
    logic [2:0]          rx;
    logic [METRIC_W-1:0] cand0    [4];
    logic [METRIC_W-1:0] cand1    [4];
    logic [METRIC_W-1:0] acs_m    [4];
    logic [DEPTH-1:0]    acs_path [4];
    logic [METRIC_W-1:0] min_m;
    logic [1:0]          best;
    logic [CNT_W-1:0]    cnt_next;

    // Hamming distance between the received word and the codeword that the
    // encoder emits for input u from state pred.
    function automatic logic [1:0] branch_metric(input logic [2:0] rx_w,
                                                 input logic [1:0] pred,
                                                 input logic       u);
        logic [2:0] exp_w;
        logic [2:0] diff;
        exp_w = {u ^ pred[0] ^ pred[1], u ^ pred[1], u ^ pred[0]};
        diff  = rx_w ^ exp_w;
        return 2'(diff[0]) + 2'(diff[1]) + 2'(diff[2]);
    endfunction

    // Saturating add: the unreachable-state metric must never wrap back
    // to a small value and win a comparison.
    function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] m,
                                                    input logic [1:0]          bm);
        logic [METRIC_W:0] sum;
        sum = {1'b0, m} + {{(METRIC_W-1){1'b0}}, bm};
        return sum[METRIC_W] ? M_MAX : sum[METRIC_W-1:0];
    endfunction

    always_comb begin
        rx    = {i_sig0, i_sig1, i_sig2};
        min_m = M_MAX;
        best  = 2'd0;

        // New state {a,u} is reached from {0,a} and {1,a}.
        // On a tie the {0,a} predecessor wins.
        for (int ns = 0; ns < 4; ns++) begin
            cand0[ns] = sat_add(metric_q[ns >> 1],
                                branch_metric(rx, 2'(ns >> 1), ns[0]));
            cand1[ns] = sat_add(metric_q[2 + (ns >> 1)],
                                branch_metric(rx, 2'(2 + (ns >> 1)), ns[0]));
            if (cand1[ns] < cand0[ns]) begin
                acs_m[ns]    = cand1[ns];
                acs_path[ns] = {path_q[2 + (ns >> 1)][DEPTH-2:0], ns[0]};
            end else begin
                acs_m[ns]    = cand0[ns];
                acs_path[ns] = {path_q[ns >> 1][DEPTH-2:0], ns[0]};
            end
        end

        // Strict compare in ascending order gives the lowest index on ties.
        // The best state is the same before or after normalization.
        for (int ns = 0; ns < 4; ns++) begin
            if (ns == 0 || acs_m[ns] < min_m) begin
                min_m = acs_m[ns];
                best  = 2'(ns);
            end
        end

        cnt_next  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;

        for (int ns = 0; ns < 4; ns++) begin
            metric_d[ns] = metric_q[ns];
            path_d[ns]   = path_q[ns];
        end
        cnt_d     = cnt_q;
        o_valid_d = 1'b0;
        o_data_d  = o_data_q;

        if (i_valid) begin
            for (int ns = 0; ns < 4; ns++) begin
                metric_d[ns] = acs_m[ns] - min_m;
                path_d[ns]   = acs_path[ns];
            end
            cnt_d     = cnt_next;
            o_valid_d = (cnt_next == CNT_FULL);
            if (cnt_next == CNT_FULL) begin
                o_data_d = acs_path[best][DEPTH-1];
            end
        end
    end

    // Encoder starts in state 00.
    // The other states begin at the metric ceiling, so they are effectively
    // excluded until a real path reaches them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ns = 0; ns < 4; ns++) begin
                metric_q[ns] <= (ns == 0) ? '0 : M_MAX;
                path_q[ns]   <= '0;
            end
            cnt_q     <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= 1'b0;
        end else begin
            for (int ns = 0; ns < 4; ns++) begin
                metric_q[ns] <= metric_d[ns];
                path_q[ns]   <= path_d[ns];
            end
            cnt_q     <= cnt_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;

endmodule

// File: tb/tb_conv_viterbi_decoder.sv
// -----------------------------------------------------------------------------
// tb_conv_viterbi_decoder
//
// Self-checking bench for conv_viterbi_decoder (DEPTH=16, METRIC_W=4).
//
// Reference model:
//   - The bench keeps the true data sequence for the current stream.
//   - It counts the symbols accepted since reset.
//   - After the k-th accepted symbol (k >= DEPTH) the next clock must show
//     o_valid=1 with o_data = u[k-DEPTH].
//   - Otherwise o_valid must be 0.
// -----------------------------------------------------------------------------
module tb_conv_viterbi_decoder;

    localparam int DEPTH    = 16;
    localparam int METRIC_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_valid = 1'b0;
    logic i_sig0 = 1'b0;
    logic i_sig1 = 1'b0;
    logic i_sig2 = 1'b0;
    logic o_valid;
    logic o_data;

    int n_cmp = 0;
    int n_err = 0;
    int acc   = 0;      // symbols accepted since last reset
    int n_out = 0;      // outputs observed in the current scenario
    bit exp_u[$];       // true data bits of the current stream

    conv_viterbi_decoder #(
        .DEPTH   (DEPTH),
        .METRIC_W(METRIC_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_valid(i_valid),
        .i_sig0 (i_sig0),
        .i_sig1 (i_sig1),
        .i_sig2 (i_sig2),
        .o_valid(o_valid),
        .o_data (o_data)
    );

    always #5 clk = ~clk;

    // Drive one cycle at the falling edge and check the registered outputs
    // 1 time unit after the following rising edge.
    task automatic step(input logic v, input logic [2:0] cw, input string tag);
        logic ev;
        logic ed;
        @(negedge clk);
        i_valid = v;
        {i_sig0, i_sig1, i_sig2} = cw;
        @(posedge clk);
        #1;
        if (v) acc++;
        ev = v && (acc >= DEPTH);
        ed = ev ? logic'(exp_u[acc - DEPTH]) : 1'b0;
        n_cmp++;
        if (o_valid !== ev) begin
            n_err++;
            $display("FAIL %s o_valid sym=%0d got=%b want=%b", tag, acc, o_valid, ev);
        end
        if (ev) begin
            n_out++;
            n_cmp++;
            if (o_data !== ed) begin
                n_err++;
                $display("FAIL %s o_data sym=%0d got=%b want=%b", tag, acc, o_data, ed);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        acc = 0;
    endtask

    task automatic check_outputs(input string tag, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s count got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_cmp++;
        if (o_valid !== 1'b0 || o_data !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got=%b%b want=00", o_valid, o_data);
        end
        @(negedge clk);
        rst = 1'b0;
        acc = 0;
        exp_u.delete();
        n_out = 0;
        step(1'b0, 3'b111, "reset_idle");
    endtask

    task automatic test_zeros();
        do_reset();
        exp_u.delete();
        for (int i = 0; i < 40; i++) exp_u.push_back(1'b0);
        n_out = 0;
        for (int i = 0; i < 40; i++) step(1'b1, 3'b000, "zeros");
        check_outputs("zeros_outputs", n_out, 25);
    endtask

    // Literal codewords for u = 1,0,1,1,0,0 followed by zeros
    task automatic test_known(input bit corrupt, input int gap, input int n_sym,
                              input bit do_rst, input string tag);
        logic [2:0] cw_tab [6];
        logic [2:0] cw;
        bit         u_tab  [6];
        cw_tab = '{3'b111, 3'b101, 3'b001, 3'b010, 3'b011, 3'b110};
        u_tab  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        if (corrupt) cw_tab[1] = 3'b100;
        if (do_rst) do_reset();
        exp_u.delete();
        for (int i = 0; i < 26; i++) exp_u.push_back(i < 6 ? u_tab[i] : 1'b0);
        n_out = 0;
        for (int i = 0; i < n_sym; i++) begin
            cw = (i < 6) ? cw_tab[i] : 3'b000;
            step(1'b1, cw, tag);
            for (int g = 0; g < gap; g++) step(1'b0, 3'($urandom_range(0, 7)), tag);
        end
        if (n_sym == 26) check_outputs(tag, n_out, 11);
    endtask

    task automatic test_reset_midstream();
        do_reset();
        test_known(1'b0, 0, 10, 1'b0, "pre_rst");
        do_reset();
        test_known(1'b0, 0, 26, 1'b0, "post_rst");
    endtask

    task automatic test_async_reset();
        do_reset();
        exp_u.delete();
        for (int i = 0; i < 20; i++) exp_u.push_back(1'b0);
        n_out = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 3'b000, "async_pre");
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst_drop o_valid got=%b want=0", o_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        acc = 0;
        exp_u.delete();
        step(1'b0, 3'b000, "async_post");
    endtask

    // Random data, isolated single-bit channel errors and random idle gaps
    task automatic test_random();
        int         next_err;
        int         n_gaps;
        bit         u;
        bit         u1;
        bit         u2;
        logic [2:0] cw;
        do_reset();
        exp_u.delete();
        for (int i = 0; i < 1000; i++) exp_u.push_back(1'($urandom_range(0, 1)));
        n_out    = 0;
        u1       = 1'b0;
        u2       = 1'b0;
        next_err = 3 + $urandom_range(0, 5);
        for (int i = 0; i < 1000; i++) begin
            u  = exp_u[i];
            cw = {u ^ u1 ^ u2, u ^ u2, u ^ u1};
            if (i == next_err) begin
                cw       = cw ^ (3'b001 << $urandom_range(0, 2));
                next_err = i + 12 + $urandom_range(0, 10);
            end
            u2 = u1;
            u1 = u;
            step(1'b1, cw, "random");
            n_gaps = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            for (int g = 0; g < n_gaps; g++) step(1'b0, 3'($urandom_range(0, 7)), "random_gap");
        end
        check_outputs("random_outputs", n_out, 1000 - DEPTH + 1);
    endtask

    initial begin
        test_reset();
        test_zeros();
        test_known(1'b0, 0, 26, 1'b1, "clean");
        test_known(1'b1, 0, 26, 1'b1, "corrupt");
        test_known(1'b0, 3, 26, 1'b1, "gaps");
        test_reset_midstream();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
